// File: rtl/datapath_pkg.sv
// Shared constants for the single-bus datapath: widths, IR field positions,
// CON condition codes and the bus-source priority encoding.
package datapath_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RA_MSB     = 26;
  localparam int RA_LSB     = 23;
  localparam int RB_MSB     = 22;
  localparam int RB_LSB     = 19;
  localparam int RC_MSB     = 18;
  localparam int RC_LSB     = 15;
  localparam int C2_MSB     = 20;
  localparam int C2_LSB     = 19;
  localparam int C_MSB      = 18;

  localparam logic [1:0] CON_EQ = 2'b00;
  localparam logic [1:0] CON_NE = 2'b01;
  localparam logic [1:0] CON_GE = 2'b10;
  localparam logic [1:0] CON_LT = 2'b11;

  // Listed in bus priority order, highest first after BUS_NONE.
  typedef enum logic [3:0] {
    BUS_NONE,
    BUS_PC,
    BUS_MDR,
    BUS_MAR,
    BUS_IR,
    BUS_Y,
    BUS_ZLO,
    BUS_ZHI,
    BUS_HI,
    BUS_LO,
    BUS_INPORT,
    BUS_C,
    BUS_R,
    BUS_BA
  } bus_src_e;

  function automatic logic [WORD_W-1:0] sext_c(input logic [WORD_W-1:0] ir);
    return {{(WORD_W-C_MSB-1){ir[C_MSB]}}, ir[C_MSB:0]};
  endfunction

endpackage

// File: rtl/datapath_select_encode.sv
// Decodes the IR register fields into one-hot register-file load/drive
// enables and produces the sign-extended constant field C.
module datapath_select_encode
  import datapath_pkg::*;
(
  input  logic [WORD_W-1:0]   ir,
  input  logic                gra,
  input  logic                grb,
  input  logic                grc,
  input  logic                rin,
  input  logic                rout,
  input  logic                baout,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [WORD_W-1:0]   c_sext
);

  logic [REG_IDX_W-1:0] idx;
  logic                 unused_opcode;

  assign unused_opcode = ^ir[OPCODE_MSB:OPCODE_LSB];

  // Field selectors OR together, so an unselected field contributes zero.
  assign idx = (gra ? ir[RA_MSB:RA_LSB] : '0)
             | (grb ? ir[RB_MSB:RB_LSB] : '0)
             | (grc ? ir[RC_MSB:RC_LSB] : '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign reg_in[gi]  = rin && (idx == REG_IDX_W'(gi));
      assign reg_out[gi] = (rout || baout) && (idx == REG_IDX_W'(gi));
    end
  endgenerate

  assign c_sext = sext_c(ir);

endmodule

// File: rtl/cpu_datapath.sv
// Single-bus 32-bit datapath: register file, special registers, adder ALU,
// RAM and I/O ports. Define DATAPATH_CON_EN to build the CON flag logic.
module cpu_datapath
  import datapath_pkg::*;
#(
  parameter int    MEM_DEPTH     = 512,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              MARout,
  input  logic              IRout,
  input  logic              RYout,
  input  logic              RZoutLo,
  input  logic              RZoutHi,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              InPortOut,
  input  logic              RCout,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              PCin,
  input  logic              IncPC,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              IRin,
  input  logic              RYin,
  input  logic              RZinLo,
  input  logic              RZinHi,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              OutPortIn,
  input  logic              InPortIn,
  input  logic              CONin,
  input  logic              Rin,
  input  logic              R1in,
  input  logic              R2in,
  input  logic              R6in,
  input  logic              MDRread,
  input  logic              RAMwrite,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic [WORD_W-1:0] InPortData,
  output logic [WORD_W-1:0] OutPortData,
  output logic              CON
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic [WORD_W-1:0] pc_reg, mar_reg, mdr_reg, ir_reg, y_reg;
  logic [WORD_W-1:0] zlo_reg, zhi_reg, hi_reg, lo_reg;
  logic [WORD_W-1:0] inport_reg, outport_reg;

  logic [WORD_W-1:0]   bus;
  bus_src_e            bus_src;
  logic [WORD_W-1:0]   sum;
  logic [WORD_W-1:0]   c_sext;
  logic [NUM_REGS-1:0] reg_in, reg_out, direct_in;
  logic [WORD_W-1:0]   reg_val [NUM_REGS];
  logic [WORD_W-1:0]   reg_sel;
  logic [WORD_W-1:0]   ram_rdata;
  logic [ADDR_W-1:0]   ram_addr;

  datapath_select_encode u_sel (
    .ir      (ir_reg),
    .gra     (Gra),
    .grb     (Grb),
    .grc     (Grc),
    .rin     (Rin),
    .rout    (Rout),
    .baout   (BAout),
    .reg_in  (reg_in),
    .reg_out (reg_out),
    .c_sext  (c_sext)
  );

  always_comb begin
    direct_in    = '0;
    direct_in[1] = R1in;
    direct_in[2] = R2in;
    direct_in[6] = R6in;
  end

  // General-purpose registers; a direct strobe and Rin may hit the same one.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [WORD_W-1:0] val_reg;
      always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
          val_reg <= '0;
        end else if (reg_in[gi] || direct_in[gi]) begin
          val_reg <= bus;
        end
      end
      assign reg_val[gi] = val_reg;
    end
  endgenerate

  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_out[i]) reg_sel = reg_sel | reg_val[i];
    end
  end

  always_comb begin
    bus_src = BUS_NONE;
    if      (PCout)     bus_src = BUS_PC;
    else if (MDRout)    bus_src = BUS_MDR;
    else if (MARout)    bus_src = BUS_MAR;
    else if (IRout)     bus_src = BUS_IR;
    else if (RYout)     bus_src = BUS_Y;
    else if (RZoutLo)   bus_src = BUS_ZLO;
    else if (RZoutHi)   bus_src = BUS_ZHI;
    else if (HIout)     bus_src = BUS_HI;
    else if (LOout)     bus_src = BUS_LO;
    else if (InPortOut) bus_src = BUS_INPORT;
    else if (RCout)     bus_src = BUS_C;
    else if (Rout)      bus_src = BUS_R;
    else if (BAout)     bus_src = BUS_BA;
  end

  always_comb begin
    bus = '0;
    case (bus_src)
      BUS_PC:     bus = pc_reg;
      BUS_MDR:    bus = mdr_reg;
      BUS_MAR:    bus = mar_reg;
      BUS_IR:     bus = ir_reg;
      BUS_Y:      bus = y_reg;
      BUS_ZLO:    bus = zlo_reg;
      BUS_ZHI:    bus = zhi_reg;
      BUS_HI:     bus = hi_reg;
      BUS_LO:     bus = lo_reg;
      BUS_INPORT: bus = inport_reg;
      BUS_C:      bus = c_sext;
      BUS_R:      bus = reg_sel;
      // Base-address read treats R0 as the constant zero.
      BUS_BA:     bus = reg_out[0] ? '0 : reg_sel;
      default:    bus = '0;
    endcase
  end

  assign sum = y_reg + bus;

  assign ram_addr  = mar_reg[ADDR_W-1:0];

  logic [WORD_W-1:0] ram [MEM_DEPTH];

  // RAM is not cleared by reset; reads are combinational from MAR.
  always_ff @(posedge clock) begin
    if (RAMwrite) ram[ram_addr] <= mdr_reg;
  end

  assign ram_rdata = ram[ram_addr];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pc_reg      <= '0;
      mar_reg     <= '0;
      mdr_reg     <= '0;
      ir_reg      <= '0;
      y_reg       <= '0;
      zlo_reg     <= '0;
      zhi_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      inport_reg  <= '0;
      outport_reg <= '0;
    end else begin
      if (IncPC)          pc_reg <= pc_reg + 1'b1;
      else if (PCin)      pc_reg <= bus;
      if (MARin)          mar_reg <= bus;
      if (MDRin)          mdr_reg <= MDRread ? ram_rdata : bus;
      if (IRin)           ir_reg <= bus;
      if (RYin)           y_reg <= bus;
      if (RZinLo)         zlo_reg <= sum;
      if (RZinHi)         zhi_reg <= {WORD_W{sum[WORD_W-1]}};
      if (HIin)           hi_reg <= bus;
      if (LOin)           lo_reg <= bus;
      if (InPortIn)       inport_reg <= InPortData;
      if (OutPortIn)      outport_reg <= bus;
    end
  end

  assign OutPortData = outport_reg;

`ifdef DATAPATH_CON_EN
  logic con_reg;
  logic con_next;

  always_comb begin
    con_next = 1'b0;
    case (ir_reg[C2_MSB:C2_LSB])
      CON_EQ:  con_next = (bus == '0);
      CON_NE:  con_next = (bus != '0);
      CON_GE:  con_next = !bus[WORD_W-1];
      default: con_next = bus[WORD_W-1];
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      con_reg <= 1'b0;
    end else if (CONin) begin
      con_reg <= con_next;
    end
  end

  assign CON = con_reg;
`else
  logic unused_con;
  assign unused_con = CONin;
  assign CON        = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed test-plan sequences, then
// randomized transfers checked against a behavioural model of the datapath.
module tb_cpu_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic        PCout, MDRout, MARout, IRout, RYout, RZoutLo, RZoutHi, HIout;
  logic        LOout, InPortOut, RCout, Rout, BAout;
  logic        PCin, IncPC, MARin, MDRin, IRin, RYin, RZinLo, RZinHi, HIin;
  logic        LOin, OutPortIn, InPortIn, CONin, Rin, R1in, R2in, R6in;
  logic        MDRread, RAMwrite, Gra, Grb, Grc;
  logic [31:0] InPortData;
  logic [31:0] OutPortData;
  logic        CON;

  always #5 clock = ~clock;

  cpu_datapath dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .MDRout(MDRout), .MARout(MARout), .IRout(IRout),
    .RYout(RYout), .RZoutLo(RZoutLo), .RZoutHi(RZoutHi), .HIout(HIout),
    .LOout(LOout), .InPortOut(InPortOut), .RCout(RCout), .Rout(Rout),
    .BAout(BAout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .RYin(RYin), .RZinLo(RZinLo), .RZinHi(RZinHi), .HIin(HIin),
    .LOin(LOin), .OutPortIn(OutPortIn), .InPortIn(InPortIn), .CONin(CONin),
    .Rin(Rin), .R1in(R1in), .R2in(R2in), .R6in(R6in), .MDRread(MDRread),
    .RAMwrite(RAMwrite), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .InPortData(InPortData), .OutPortData(OutPortData), .CON(CON)
  );

  int errors = 0;
  int checks = 0;

`ifdef DATAPATH_CON_EN
  localparam bit CON_BUILT = 1'b1;
`else
  localparam bit CON_BUILT = 1'b0;
`endif

  // Behavioural model of the architectural state.
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zlo, m_zhi, m_hi, m_lo;
  logic [31:0] m_in, m_out;
  logic        m_con;
  logic [31:0] m_ram [512];
  bit          m_valid [512];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %-10s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %-10s got=0x%08h", tag, got);
    end
  endtask

  task automatic set_all(input logic v);
    {PCout, MDRout, MARout, IRout, RYout, RZoutLo, RZoutHi, HIout, LOout,
     InPortOut, RCout, Rout, BAout} = {13{v}};
    {PCin, IncPC, MARin, MDRin, IRin, RYin, RZinLo, RZinHi, HIin, LOin,
     OutPortIn, InPortIn, CONin, Rin, R1in, R2in, R6in} = {17{v}};
    {MDRread, RAMwrite, Gra, Grb, Grc} = {5{v}};
  endtask

  task automatic idle();
    set_all(1'b0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_r[k] = '0;
    {m_pc, m_ir, m_mar, m_mdr, m_y, m_zlo, m_zhi, m_hi, m_lo, m_in, m_out} = '0;
    m_con = 1'b0;
  endtask

  function automatic logic [3:0] model_idx();
    logic [3:0] ra, rb, rc;
    ra = m_ir[26:23];
    rb = m_ir[22:19];
    rc = m_ir[18:15];
    return (Gra ? ra : 4'd0) | (Grb ? rb : 4'd0) | (Grc ? rc : 4'd0);
  endfunction

  // First asserted driver in priority order owns the bus.
  function automatic logic [31:0] model_bus();
    logic [3:0]  idx;
    logic        drv  [13];
    logic [31:0] vals [13];
    logic signed [18:0] c;
    idx  = model_idx();
    c    = m_ir[18:0];
    drv  = '{PCout, MDRout, MARout, IRout, RYout, RZoutLo, RZoutHi, HIout,
             LOout, InPortOut, RCout, Rout, BAout};
    vals = '{m_pc, m_mdr, m_mar, m_ir, m_y, m_zlo, m_zhi, m_hi, m_lo, m_in,
             32'(c), m_r[idx], (idx == 4'd0) ? 32'd0 : m_r[idx]};
    for (int i = 0; i < 13; i++) begin
      if (drv[i]) return vals[i];
    end
    return 32'd0;
  endfunction

  // One clock: compute the model's next state from the present strobes,
  // let the edge pass, commit, and compare the visible outputs.
  task automatic step();
    logic [31:0] b, s, n_pc, n_mar, n_mdr, n_ir, n_y, n_zlo, n_zhi;
    logic [31:0] n_hi, n_lo, n_in, n_out;
    logic [31:0] n_r [16];
    logic        n_con;
    logic [3:0]  idx;
    logic [8:0]  addr;
    b     = model_bus();
    idx   = model_idx();
    addr  = m_mar[8:0];
    s     = m_y + b;
    n_r   = m_r;
    for (int k = 0; k < 16; k++) begin
      if ((Rin && idx == 4'(k)) || (k == 1 && R1in) || (k == 2 && R2in) || (k == 6 && R6in))
        n_r[k] = b;
    end
    n_pc  = IncPC ? m_pc + 32'd1 : (PCin ? b : m_pc);
    n_mar = MARin ? b : m_mar;
    n_mdr = MDRin ? (MDRread ? m_ram[addr] : b) : m_mdr;
    n_ir  = IRin ? b : m_ir;
    n_y   = RYin ? b : m_y;
    n_zlo = RZinLo ? s : m_zlo;
    n_zhi = RZinHi ? (($signed(s) < 0) ? 32'hFFFF_FFFF : 32'd0) : m_zhi;
    n_hi  = HIin ? b : m_hi;
    n_lo  = LOin ? b : m_lo;
    n_in  = InPortIn ? InPortData : m_in;
    n_out = OutPortIn ? b : m_out;
    n_con = m_con;
    if (CON_BUILT && CONin) begin
      case (m_ir[20:19])
        2'b00:   n_con = (b == 32'd0);
        2'b01:   n_con = (b != 32'd0);
        2'b10:   n_con = ($signed(b) >= 0);
        default: n_con = ($signed(b) < 0);
      endcase
    end
    if (RAMwrite) begin
      m_ram[addr]   = m_mdr;
      m_valid[addr] = 1'b1;
    end
    @(posedge clock);
    #1;
    m_r = n_r;
    m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_ir = n_ir; m_y = n_y;
    m_zlo = n_zlo; m_zhi = n_zhi; m_hi = n_hi; m_lo = n_lo;
    m_in = n_in; m_out = n_out; m_con = n_con;
    check_val("outport", OutPortData, m_out);
    check_val("con", {31'd0, CON}, {31'd0, m_con});
  endtask

  // Load a word into the input port and then copy it onto one destination.
  task automatic load_in(input logic [31:0] v);
    idle(); InPortData = v; InPortIn = 1'b1; step();
    idle(); InPortOut = 1'b1;
  endtask

  task automatic set_driver(input int n);
    case (n)
      0: PCout = 1'b1;   1: MDRout = 1'b1;    2: MARout = 1'b1;
      3: IRout = 1'b1;   4: RYout = 1'b1;     5: RZoutLo = 1'b1;
      6: RZoutHi = 1'b1; 7: HIout = 1'b1;     8: LOout = 1'b1;
      9: InPortOut = 1'b1; 10: RCout = 1'b1;  11: Rout = 1'b1;
      12: BAout = 1'b1;
      default: ;
    endcase
  endtask

  function automatic logic chance(input int denom);
    return $urandom_range(denom - 1, 0) == 0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 512; a++) begin m_ram[a] = '0; m_valid[a] = 1'b0; end
    model_reset();

    // Reset with every strobe asserted across a clock edge.
    clear = 1'b0;
    set_all(1'b1);
    InPortData = 32'hFFFF_FFFF;
    #12;
    check_val("rst_bus", dut.bus, 32'd0);
    check_val("rst_out", OutPortData, 32'd0);
    check_val("rst_con", {31'd0, CON}, 32'd0);
    idle();
    @(negedge clock);
    clear = 1'b1;
    step();
    idle(); PCout = 1'b1; OutPortIn = 1'b1; step();
    check_val("rst_pc", OutPortData, 32'd0);

    // Preload RAM[0] with the LDI instruction (MAR is 0 after reset).
    load_in(32'h4990_0055); MDRin = 1'b1; step();
    idle(); RAMwrite = 1'b1; step();

    // LDI R3, 0x55(R2)
    idle(); PCin = 1'b1; R2in = 1'b1; step();
    idle(); PCout = 1'b1; MARin = 1'b1; step();
    idle(); MDRread = 1'b1; MDRin = 1'b1; IncPC = 1'b1; step();
    idle(); MDRout = 1'b1; IRin = 1'b1; step();
    idle(); Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; step();
    idle(); RCout = 1'b1; RZinLo = 1'b1; step();
    idle(); RZoutLo = 1'b1; Gra = 1'b1; Rin = 1'b1; step();
    idle(); Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; step();
    check_val("ldi_r3", OutPortData, 32'h0000_0055);
    idle(); PCout = 1'b1; OutPortIn = 1'b1; step();
    check_val("ldi_pc", OutPortData, 32'd1);

    // BAout with rb = 0 reads zero even though R0 holds 7.
    load_in(32'd7); Rin = 1'b1; step();
    load_in({5'd9, 4'd3, 4'd0, 19'h00123}); IRin = 1'b1; step();
    idle(); Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; step();
    idle(); RCout = 1'b1; RZinLo = 1'b1; step();
    idle(); RZoutLo = 1'b1; Gra = 1'b1; Rin = 1'b1; step();
    idle(); RYout = 1'b1; OutPortIn = 1'b1; step();
    check_val("ba_y", OutPortData, 32'd0);
    idle(); Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; step();
    check_val("ba_r3", OutPortData, 32'h0000_0123);
    idle(); Rout = 1'b1; OutPortIn = 1'b1; step();
    check_val("ba_r0", OutPortData, 32'd7);

    // Negative displacement: 0x10 + (-1).
    load_in(32'h10); R2in = 1'b1; step();
    load_in({5'd9, 4'd3, 4'd2, 19'h7FFFF}); IRin = 1'b1; step();
    idle(); Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; step();
    idle(); RCout = 1'b1; RZinLo = 1'b1; RZinHi = 1'b1; step();
    idle(); RZoutLo = 1'b1; Gra = 1'b1; Rin = 1'b1; step();
    idle(); Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; step();
    check_val("negc_r3", OutPortData, 32'h0000_000F);
    idle(); RZoutHi = 1'b1; OutPortIn = 1'b1; step();
    check_val("negc_zhi", OutPortData, 32'd0);

    // Store then load back, plus same-cycle write/read.
    load_in(32'hDEAD_BEEF); MDRin = 1'b1; step();
    load_in(32'd5); MARin = 1'b1; step();
    idle(); RAMwrite = 1'b1; step();
    idle(); MDRin = 1'b1; step();
    idle(); MDRread = 1'b1; MDRin = 1'b1; step();
    idle(); MDRout = 1'b1; OutPortIn = 1'b1; step();
    check_val("ld_mdr", OutPortData, 32'hDEAD_BEEF);
    load_in(32'h1234_5678); MDRin = 1'b1; step();
    idle(); RAMwrite = 1'b1; MDRread = 1'b1; MDRin = 1'b1; step();
    idle(); MDRout = 1'b1; OutPortIn = 1'b1; step();
    check_val("rw_old", OutPortData, 32'hDEAD_BEEF);
    idle(); MDRread = 1'b1; MDRin = 1'b1; step();
    idle(); MDRout = 1'b1; OutPortIn = 1'b1; step();
    check_val("rw_new", OutPortData, 32'h1234_5678);

    // I/O ports: the input port only changes on InPortIn.
    load_in(32'hA5); OutPortIn = 1'b1; step();
    check_val("io_a5", OutPortData, 32'h0000_00A5);
    idle(); InPortData = 32'h5A; InPortOut = 1'b1; OutPortIn = 1'b1; step();
    check_val("io_hold", OutPortData, 32'h0000_00A5);

    // CON: C2=01 against zero, then C2=11 against a negative word.
    load_in({5'd0, 4'd0, 4'b0001, 19'd0}); IRin = 1'b1; step();
    idle(); CONin = 1'b1; step();
    check_val("con_ne0", {31'd0, CON}, 32'd0);
    load_in({5'd0, 4'd0, 4'b0011, 19'd0}); IRin = 1'b1; step();
    load_in(32'h8000_0000); CONin = 1'b1; step();
    check_val("con_lt", {31'd0, CON}, {31'd0, CON_BUILT});

    // PC wrap, IncPC over PCin, and bus priority.
    load_in(32'hFFFF_FFFF); PCin = 1'b1; step();
    idle(); IncPC = 1'b1; PCin = 1'b1; InPortOut = 1'b1; step();
    idle(); PCout = 1'b1; InPortOut = 1'b1; OutPortIn = 1'b1; step();
    check_val("pc_wrap", OutPortData, 32'd0);
    idle(); InPortOut = 1'b1; RCout = 1'b1; OutPortIn = 1'b1; step();
    check_val("prio_in", OutPortData, 32'hFFFF_FFFF);

    // Clear asserted in the middle of a cycle aborts everything.
    idle(); InPortOut = 1'b1; OutPortIn = 1'b1; MDRin = 1'b1; R1in = 1'b1;
    #3;
    clear = 1'b0;
    #1;
    model_reset();
    check_val("mid_out", OutPortData, 32'd0);
    check_val("mid_bus", dut.bus, 32'd0);
    @(negedge clock);
    idle();
    @(negedge clock);
    clear = 1'b1;
    idle(); MDRout = 1'b1; OutPortIn = 1'b1; step();
    check_val("mid_mdr", OutPortData, 32'd0);
    idle(); R1in = 1'b0; Grc = 1'b0; Rout = 1'b1; OutPortIn = 1'b1; step();
    check_val("mid_r0", OutPortData, 32'd0);

    // Randomized transfers against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      InPortData = $urandom;
      set_driver($urandom_range(13, 0));
      if (chance(8)) set_driver($urandom_range(12, 0));
      {Gra, Grb, Grc} = 3'($urandom);
      PCin = chance(6);  IncPC = chance(6);  MARin = chance(3);
      MDRin = chance(3); IRin = chance(4);   RYin = chance(3);
      RZinLo = chance(3); RZinHi = chance(3); HIin = chance(4);
      LOin = chance(4);  OutPortIn = chance(2); InPortIn = chance(2);
      CONin = chance(3); Rin = chance(3);    R1in = chance(5);
      R2in = chance(5);  R6in = chance(5);   RAMwrite = chance(3);
      MDRread = chance(2) && m_valid[m_mar[8:0]];
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
